// File: rtl/load_store_unit.sv
// Load/store unit: takes the ALU result as the effective address, runs one
// req/ack data-memory transaction per load or store, aligns and extends load
// data, and replicates store data with byte enables. The core is held in
// stall until the access completes, is rejected, or times out.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // Last BUS cycle in which an ack is still accepted.
    localparam logic [15:0] L_CNT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        r_is_store, w_is_store_nxt;
    logic [2:0]  r_funct3, w_funct3_nxt;
    logic [1:0]  r_lane, w_lane_nxt;
    logic        r_done, w_done_nxt;
    logic        r_misalign, w_misalign_nxt;
    logic        r_bus_err, w_bus_err_nxt;
    logic        r_mem_req, w_mem_req_nxt;
    logic        r_mem_we, w_mem_we_nxt;
    logic [31:0] r_mem_addr, w_mem_addr_nxt;
    logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [3:0]  r_mem_be, w_mem_be_nxt;
    logic [31:0] r_load_data, w_load_data_nxt;

    // Legal funct3 for the direction, and address aligned to the access width.
    function automatic logic f_req_ok(input logic st, input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~lo[0];
            3'b010:  ok = (lo == 2'b00);
            3'b100:  ok = ~st;
            3'b101:  ok = ~st & ~lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Store data replicated across every lane the access could land in.
    function automatic logic [31:0] f_store_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] wd;
        case (f3)
            3'b000:  wd = {4{sd[7:0]}};
            3'b001:  wd = {2{sd[15:0]}};
            default: wd = sd;
        endcase
        return wd;
    endfunction

    // Byte enables for a store at the given byte offset.
    function automatic logic [3:0] f_store_be(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] be;
        case (f3)
            3'b000:  be = 4'b0001 << lo;
            3'b001:  be = lo[1] ? 4'b1100 : 4'b0011;
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Lane select plus sign/zero extension of the returned word.
    function automatic logic [31:0] f_load_ext(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = rd[{lane, 3'b000} +: 8];
        h = rd[{lane[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b100:  res = {24'h000000, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b101:  res = {16'h0000, h};
            3'b010:  res = rd;
            default: res = 32'h00000000;
        endcase
        return res;
    endfunction

    // The core must hold while a request is being taken or the bus is busy.
    assign stall = ((r_state == S_IDLE) && start) || (r_state == S_BUS);

    assign done      = r_done;
    assign misalign  = r_misalign;
    assign bus_err   = r_bus_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign load_data = r_load_data;

    // Next-state and next-output logic; completion flags default to a single-cycle pulse.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_is_store_nxt  = r_is_store;
        w_funct3_nxt    = r_funct3;
        w_lane_nxt      = r_lane;
        w_done_nxt      = 1'b0;
        w_misalign_nxt  = 1'b0;
        w_bus_err_nxt   = 1'b0;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_be_nxt    = r_mem_be;
        w_load_data_nxt = r_load_data;
        case (r_state)
            S_IDLE: begin
                if (start && f_req_ok(is_store, funct3, addr[1:0])) begin
                    w_state_nxt     = S_BUS;
                    w_cnt_nxt       = 16'h0000;
                    w_is_store_nxt  = is_store;
                    w_funct3_nxt    = funct3;
                    w_lane_nxt      = addr[1:0];
                    w_load_data_nxt = 32'h00000000;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = is_store;
                    w_mem_addr_nxt  = {addr[31:2], 2'b00};
                    w_mem_wdata_nxt = is_store ? f_store_wdata(funct3, store_data) : 32'h00000000;
                    w_mem_be_nxt    = is_store ? f_store_be(funct3, addr[1:0]) : 4'b0000;
                end else if (start) begin
                    // Rejected request: report it without touching the bus.
                    w_state_nxt     = S_ERR;
                    w_done_nxt      = 1'b1;
                    w_misalign_nxt  = 1'b1;
                    w_load_data_nxt = 32'h00000000;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUS: begin
                if (mem_ack) begin
                    // An ack on the terminal-count cycle still wins over the timeout.
                    w_state_nxt     = S_RESP;
                    w_done_nxt      = 1'b1;
                    w_mem_req_nxt   = 1'b0;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = 32'h00000000;
                    w_mem_wdata_nxt = 32'h00000000;
                    w_mem_be_nxt    = 4'b0000;
                    w_load_data_nxt = r_is_store ? 32'h00000000 : f_load_ext(r_funct3, r_lane, mem_rdata);
                end else if (r_cnt == L_CNT_LAST) begin
                    w_state_nxt     = S_ERR;
                    w_done_nxt      = 1'b1;
                    w_bus_err_nxt   = 1'b1;
                    w_mem_req_nxt   = 1'b0;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = 32'h00000000;
                    w_mem_wdata_nxt = 32'h00000000;
                    w_mem_be_nxt    = 4'b0000;
                    w_load_data_nxt = 32'h00000000;
                end else begin
                    w_cnt_nxt = r_cnt + 16'h0001;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and registered outputs, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 16'h0000;
            r_is_store  <= 1'b0;
            r_funct3    <= 3'b000;
            r_lane      <= 2'b00;
            r_done      <= 1'b0;
            r_misalign  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h00000000;
            r_mem_wdata <= 32'h00000000;
            r_mem_be    <= 4'b0000;
            r_load_data <= 32'h00000000;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_is_store  <= w_is_store_nxt;
            r_funct3    <= w_funct3_nxt;
            r_lane      <= w_lane_nxt;
            r_done      <= w_done_nxt;
            r_misalign  <= w_misalign_nxt;
            r_bus_err   <= w_bus_err_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_load_data <= w_load_data_nxt;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios followed by randomized
// accesses, all compared against an arithmetic reference model.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst, start, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, mem_rdata;
    logic        mem_ack;
    logic        stall, done, misalign, bus_err, mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .store_data(store_data), .stall(stall), .done(done),
        .load_data(load_data), .misalign(misalign), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: is the request legal and aligned?
    function automatic bit m_ok(input bit st, input int f3, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (f3 == 0) return 1'b1;
        if (f3 == 1) return (off % 2) == 0;
        if (f3 == 2) return off == 0;
        if (!st && f3 == 4) return 1'b1;
        if (!st && f3 == 5) return (off % 2) == 0;
        return 1'b0;
    endfunction

    // Reference: extended load result computed with shifts and masks.
    function automatic logic [31:0] m_load(input int f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        if (f3 == 2) return rd;
        if (f3 == 0 || f3 == 4) begin
            v = (rd >> (8 * (a % 4))) & 32'h000000FF;
            if (f3 == 0 && v >= 32'h00000080) v = v | 32'hFFFFFF00;
        end else begin
            v = (rd >> (16 * ((a / 2) % 2))) & 32'h0000FFFF;
            if (f3 == 1 && v >= 32'h00008000) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    // Reference: replicated store data.
    function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] sd);
        if (f3 == 0) return (sd & 32'h000000FF) * 32'h01010101;
        if (f3 == 1) return (sd & 32'h0000FFFF) * 32'h00010001;
        return sd;
    endfunction

    // Reference: byte enables.
    function automatic logic [3:0] m_be(input int f3, input logic [31:0] a);
        logic [3:0] one;
        one = 4'b0001;
        if (f3 == 0) return one << (a % 4);
        if (f3 == 1) return (((a / 2) % 2) == 1) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    // One instruction: present it, serve the bus with ack after wait_c extra cycles
    // (never if wait_c >= TO), then check the completion pulse and return to idle.
    task automatic run_op(input string nm, input bit st, input int f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd, input int wait_c);
        bit ok, tmo;
        int n_bus;
        logic [31:0] exp_ld;
        ok    = m_ok(st, f3, a);
        tmo   = ok && (wait_c >= TO);
        n_bus = !ok ? 0 : (tmo ? TO : wait_c + 1);
        exp_ld = (ok && !tmo && !st) ? m_load(f3, a, rd) : 32'h00000000;
        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = 3'(f3); addr = a; store_data = sd;
        mem_rdata = rd; mem_ack = 1'b0;
        #1;
        chk({nm, ":stall_accept"}, 32'(stall), 32'd1);
        for (int k = 0; k < n_bus; k++) begin
            @(negedge clk);
            mem_ack = (k == wait_c);
            chk({nm, ":req"}, 32'(mem_req), 32'd1);
            chk({nm, ":stall_bus"}, 32'(stall), 32'd1);
            chk({nm, ":done_early"}, 32'(done), 32'd0);
            chk({nm, ":addr"}, mem_addr, a & 32'hFFFFFFFC);
            chk({nm, ":we"}, 32'(mem_we), 32'(st));
            chk({nm, ":be"}, 32'(mem_be), st ? 32'(m_be(f3, a)) : 32'd0);
            if (st) chk({nm, ":wdata"}, mem_wdata, m_wdata(f3, sd));
        end
        @(negedge clk);
        mem_ack = 1'($urandom_range(0, 1));   // stray ack during completion must be ignored
        chk({nm, ":done"}, 32'(done), 32'd1);
        chk({nm, ":misalign"}, 32'(misalign), 32'(!ok));
        chk({nm, ":bus_err"}, 32'(bus_err), 32'(tmo));
        chk({nm, ":req_drop"}, 32'(mem_req), 32'd0);
        chk({nm, ":stall_end"}, 32'(stall), 32'd0);
        chk({nm, ":load_data"}, load_data, exp_ld);
        start = 1'b0;
        @(negedge clk);
        chk({nm, ":done_pulse"}, 32'(done), 32'd0);
        chk({nm, ":req_idle"}, 32'(mem_req), 32'd0);
        chk({nm, ":flags_idle"}, 32'({misalign, bus_err}), 32'd0);
        mem_ack = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ":done"}, 32'(done), 32'd0);
        chk({nm, ":flags"}, 32'({misalign, bus_err}), 32'd0);
        chk({nm, ":req_we"}, 32'({mem_req, mem_we}), 32'd0);
        chk({nm, ":addr"}, mem_addr, 32'd0);
        chk({nm, ":wdata"}, mem_wdata, 32'd0);
        chk({nm, ":be"}, 32'(mem_be), 32'd0);
        chk({nm, ":load_data"}, load_data, 32'd0);
        chk({nm, ":stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        int lf[5];
        bit st;
        int f3, w;
        logic [31:0] a;
        lf[0] = 0; lf[1] = 1; lf[2] = 2; lf[3] = 4; lf[4] = 5;
        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0;
        store_data = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        run_op("lw_basic", 1'b0, 2, 32'h00000100, 32'h0, 32'hDEADBEEF, 0);
        run_op("lb_neg",   1'b0, 0, 32'h00000103, 32'h0, 32'h80FF0000, 0);
        run_op("lbu",      1'b0, 4, 32'h00000103, 32'h0, 32'h80FF0000, 1);
        run_op("lh_hi",    1'b0, 1, 32'h00000102, 32'h0, 32'h80FF0000, 2);
        run_op("lhu_lo",   1'b0, 5, 32'h00000100, 32'h0, 32'h1234F00D, 0);
        run_op("sh_wait3", 1'b1, 1, 32'h00000206, 32'h1234ABCD, 32'h0, 3);
        run_op("sb_lane2", 1'b1, 0, 32'h00000312, 32'h000000A5, 32'h0, 1);
        run_op("sw",       1'b1, 2, 32'h00000400, 32'hCAFEF00D, 32'h0, 0);
        run_op("lw_mis",   1'b0, 2, 32'h00000101, 32'h0, 32'hFFFFFFFF, 0);
        run_op("sb_ill",   1'b1, 3, 32'h00000100, 32'h0, 32'h0, 0);
        run_op("lh_mis",   1'b0, 1, 32'h00000103, 32'h0, 32'h0, 0);
        run_op("timeout",  1'b0, 2, 32'h00000500, 32'h0, 32'h11111111, TO);
        run_op("timeout2", 1'b1, 2, 32'h00000504, 32'h22222222, 32'h0, TO + 3);

        // Reset in the middle of a bus access, then a stray ack.
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h00000300; mem_ack = 1'b0;
        @(negedge clk);
        chk("rst_mid:req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; mem_ack = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rst_stray:done", 32'(done), 32'd0);
        chk("rst_stray:req", 32'(mem_req), 32'd0);
        run_op("lw_after_rst", 1'b0, 2, 32'h00000300, 32'h0, 32'h0BADF00D, 0);

        for (int i = 0; i < 40; i++) begin
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) f3 = int'($urandom_range(0, 7));
            else if (st) f3 = int'($urandom_range(0, 2));
            else f3 = lf[$urandom_range(0, 4)];
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3 == 2) a = a & 32'hFFFFFFFC;
                else if (f3 == 1 || f3 == 5) a = a & 32'hFFFFFFFE;
            end
            w = int'($urandom_range(0, 5));
            run_op("rand", st, f3, a, $urandom, $urandom, w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
